// File: rtl/fp4_mac_pkg.sv
// Shared types and constants for the FP4 x INT8 MAC array.
// FSM state encoding, FP4 (E3M0) field positions and product width.
package fp4_mac_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACCUM      = 2'd1,
      FLUSH_WAIT = 2'd2
   } state_t;

   localparam int FP4_SIGN_BIT = 3;
   localparam int FP4_EXP_MSB  = 2;
   localparam int FP4_EXP_LSB  = 0;
   localparam int FP4_EXP_W    = FP4_EXP_MSB - FP4_EXP_LSB + 1;
   localparam int PROD_W       = 15;

endpackage

// File: rtl/fp4_i8_mul.sv
// Combinational FP4 (E3M0) x signed INT8 multiplier producing a signed 15-bit product.
// Exponent 0 encodes zero regardless of sign; otherwise +/-(i8 <<< (e-1)).
module fp4_i8_mul
   import fp4_mac_pkg::*;
(
   input  logic        [3:0]        fp4,
   input  logic signed [7:0]        i8,
   output logic signed [PROD_W-1:0] prod
);

   logic        [FP4_EXP_W-1:0] e;
   logic signed [PROD_W-1:0]    mag;

   always_comb begin
      e    = fp4[FP4_EXP_MSB:FP4_EXP_LSB];
      mag  = '0;
      prod = '0;
      if (e != '0) begin
         // Largest magnitude is 128 << 6 = 8192, which fits the signed 15-bit range after negation.
         mag  = {{(PROD_W-8){i8[7]}}, i8} <<< (e - 3'd1);
         prod = fp4[FP4_SIGN_BIT] ? -mag : mag;
      end
   end

endmodule

// File: rtl/fp4_mac_array.sv
// ROWS x COLS FP4-by-INT8 accumulator array with a row-major output drain queue.
// Define FP4_MAC_RELU_EN to clamp negative elements to zero at readout.
module fp4_mac_array
   import fp4_mac_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 2,
   parameter int ACC_W     = 24,
   parameter int OUT_SHIFT = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [ROWS*4-1:0] in_left,
   input  logic [COLS*8-1:0] in_top,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t state, state_next;

   logic signed [PROD_W-1:0] prod     [N];
   logic signed [ACC_W-1:0]  acc      [N];
   logic signed [ACC_W-1:0]  acc_next [N];
   logic signed [ACC_W-1:0]  queue    [N];
   logic [IDX_W-1:0]         rd_idx;
   logic                     q_valid;

   logic accept;
   logic emptying;
   logic q_free;
   logic capture;

   function automatic logic [7:0] readout(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = v >>> OUT_SHIFT;
`ifdef FP4_MAC_RELU_EN
      if (v[ACC_W-1]) s = '0;
`endif
      return s[7:0];
   endfunction

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         fp4_i8_mul u_mul (
            .fp4  (in_left[r*4 +: 4]),
            .i8   (in_top[c*8 +: 8]),
            .prod (prod[r*COLS + c])
         );
      end
   end

   assign accept   = in_valid & in_ready;
   assign emptying = out_valid & out_ready & out_last;
   assign q_free   = ~q_valid | emptying;
   // A finished tile moves to the queue as soon as the queue is free, either on its last beat or from FLUSH_WAIT.
   assign capture  = q_free & ((accept & in_last) | (state == FLUSH_WAIT));

   always_comb begin
      for (int i = 0; i < N; i++) begin
         acc_next[i] = acc[i];
         if (accept) begin
            acc_next[i] = acc[i] + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset || capture) begin
            acc[i] <= '0;
         end else begin
            acc[i] <= acc_next[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) queue[i] <= '0;
         rd_idx  <= '0;
         q_valid <= 1'b0;
      end else if (capture) begin
         for (int i = 0; i < N; i++) queue[i] <= acc_next[i];
         rd_idx  <= '0;
         q_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         if (out_last) begin
            rd_idx  <= '0;
            q_valid <= 1'b0;
         end else begin
            rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

   assign out_valid = q_valid;
   assign out_last  = q_valid && (rd_idx == IDX_W'(N-1));
   assign out_data  = q_valid ? readout(queue[rd_idx]) : 8'h00;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               if (in_last) begin
                  state_next = capture ? IDLE : FLUSH_WAIT;
               end else begin
                  state_next = ACCUM;
               end
            end
         end
         FLUSH_WAIT: begin
            if (capture) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state != FLUSH_WAIT);
   end

endmodule

// File: doc/fp4_mac_array.md
FP4_MAC_ARRAY -- requirements
Module: fp4_mac_array

Interface
REQ-001 SHALL have parameter ROWS, default 4, the number of FP4 (left) operands and accumulator rows.
REQ-002 SHALL have parameter COLS, default 2, the number of INT8 (top) operands and accumulator columns.
REQ-003 SHALL have parameter ACC_W, default 24, the signed accumulator width; legal range 16..32.
REQ-004 SHALL have parameter OUT_SHIFT, default 10, the arithmetic right shift applied at readout.
REQ-005 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-009 SHALL have port in_last, input, 1 bit: the beat is the final K-step of the tile.
REQ-010 SHALL have port in_left, input, ROWS*4 bits: FP4 operands; row r sits at [r*4 +: 4].
REQ-011 SHALL have port in_top, input, COLS*8 bits: signed INT8 operands; column c sits at [c*8 +: 8].
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the element.
REQ-014 SHALL have port out_data, output, 8 bits: the scaled result element.
REQ-015 SHALL have port out_last, output, 1 bit: marks the final element of the tile.

Function
REQ-016 Beat acceptance SHALL be in_valid and in_ready.
- On each accepted beat, for every r and c: acc[r][c] += fp4mul(left[r], top[c]).
REQ-017 fp4mul SHALL follow the E3M0 format: bit3 is the sign and bits[2:0] are the exponent e.
- e = 0: result is 0, for either sign.
- Otherwise: result is ±(i8 <<< (e-1)), carried as a 15-bit signed product.
REQ-018 The product SHALL be sign-extended to ACC_W bits before accumulation.
- Accumulation wraps modulo 2^ACC_W; there is no saturation.
REQ-019 The FSM SHALL have three states: IDLE, ACCUM and FLUSH_WAIT.
- in_ready is 1 in IDLE and in ACCUM, and 0 in FLUSH_WAIT.
REQ-020 A beat accepted with in_last = 0 SHALL move the FSM to ACCUM (or hold it there).
REQ-021 A beat accepted with in_last = 1 SHALL capture the tile if the output queue is empty, or is emptying this cycle.
- Emptying this cycle means out_valid, out_ready and out_last are all 1.
- Capture copies all ROWS*COLS next-accumulator values, including this beat's products, into the output queue.
- Capture also clears the accumulators, and the FSM goes to IDLE.
- If the queue is not empty, the FSM goes to FLUSH_WAIT and the accumulators hold their values, including this beat's products.
REQ-022 In FLUSH_WAIT, the FSM SHALL capture (as in REQ-021) and go to IDLE in the cycle the queue becomes empty.
REQ-023 The output queue SHALL present elements in row-major order, index r*COLS+c.
- The first element is valid the cycle after capture.
- Each out_valid and out_ready handshake advances the queue by one element.
- out_data holds stable while out_ready = 0.
REQ-024 out_data SHALL be bits [7:0] of (element >>> OUT_SHIFT).
REQ-025 out_last SHALL be 1 exactly while element ROWS*COLS-1 is presented.
REQ-026 Throughput SHALL be one input beat per cycle while in_ready = 1, and one output element per cycle while out_ready = 1.
- Accumulation of the next tile overlaps draining of the current one.

Reset
REQ-027 On reset = 1 the block SHALL clear:
- all accumulators;
- the output queue, so out_valid = 0, out_last = 0 and out_data = 0;
- the FSM, to IDLE, so in_ready = 1 in the following cycle.
REQ-028 Reset SHALL take priority over any simultaneous handshake; a reset mid-tile or mid-drain discards all data.

Configuration
REQ-029 With macro FP4_MAC_RELU_EN defined, out_data SHALL be 0 whenever the element is negative.
- Without the macro, out_data follows REQ-024 unmodified.

Structure
REQ-030 A shared package fp4_mac_pkg SHALL hold:
- the FSM state enum;
- the FP4 field constants: sign bit 3, exponent bits [2:0];
- the product width constant, 15.
REQ-031 The multiplier SHALL be a combinational sub-module, fp4_i8_mul (fp4, i8 -> signed 15-bit).
- It is instantiated ROWS*COLS times.

Verification
REQ-032 With OUT_SHIFT = 0, one beat with in_last = 1, left[0] = 4'b0001 and top[0] = 5: element 0 SHALL read 5 and all other elements 0; out_last SHALL assert on element 7.
REQ-033 With OUT_SHIFT = 0, one beat with in_last = 1, left[0] = 4'b1011 and top[0] = 3: out_data SHALL be 8'hF4, or 8'h00 with FP4_MAC_RELU_EN.
REQ-034 With OUT_SHIFT = 0, three beats with left[0] = 4'b0111 and top[0] = 1, in_last on beat 3: element 0 SHALL read 8'hC0 (192).
REQ-035 Drain a tile with out_ready = 0, send a second tile's in_last, then raise out_ready:
- in_ready SHALL be 0 (FLUSH_WAIT) until the first tile's last element is accepted;
- the second tile's values SHALL follow with no loss.
REQ-036 Assert reset while 3 elements are still queued: the next cycle SHALL show out_valid = 0 and in_ready = 1, and a following tile SHALL start from zero accumulators.
